abs_arbiter: RTL and testbench
==============================

// Module: abs_arbiter
// PURPOSE
//  Shares one absolute-value datapath (sign_negator + mux2to1) between N requesters.
//  Round-robin arbitration over a valid/ready handshake; one registered result slot.
//  Sits between the ALU operand sources and the result bus.
// PARAMETERS
//  w    16  data width (two's complement)
//  N    4   number of requesters (2..8)
//  IDW  2   width of res_id; must be >= clog2(N)
// PORTS
//  clk        in   1      clock, all state updates on rising edge
//  rst        in   1      synchronous reset, active-high
//  req_valid  in   N      bit i: requester i presents an operand
//  req_data   in   N*w    operand i in bits [i*w +: w], signed
//  req_ready  out  N      one-hot grant; bit i high = operand i taken this cycle
//  res_valid  out  1      result register holds a valid result
//  res_data   out  w      |operand| of the granted request
//  res_id     out  IDW    index of the requester that produced res_data
//  res_ovf    out  1      result saturated (ABS_SAT_EN only, else constant 0)
//  res_ready  in   1      consumer takes the result this cycle
// BEHAVIOUR
//  Reset: res_valid=0, res_data=0, res_id=0, res_ovf=0, state=IDLE, rr_ptr=0. req_ready is 0 during reset.
//  FSM states:
//    IDLE: slot empty.
//    HOLD: slot full.
//  Accept condition: accept = (state==IDLE) | (state==HOLD & res_ready).
//  Grant (combinational):
//    If accept and any req_valid, pick the first set bit scanning rr_ptr, rr_ptr+1, ... mod N.
//    req_ready = one-hot of that bit.
//    Otherwise req_ready = 0.
//    req_ready never depends on res_valid of the same requester.
//  Transfer occurs on the edge where req_valid[i] & req_ready[i]. On that edge:
//    res_data <= abs(req_data[i]); res_id <= i; res_valid <= 1;
//    rr_ptr <= (i+1) mod N; state <= HOLD.
//  Consumer transfer: res_valid & res_ready.
//    With no simultaneous accept of a new request: res_valid <= 0, state <= IDLE, data/id hold.
//    With a simultaneous accept: the new result replaces the old one and state stays HOLD.
//    Throughput is 1 result/cycle.
//  Latency: operand accepted on edge k -> res_valid high from cycle k+1.
//  HOLD & !res_ready: res_data/res_id/res_ovf stable; req_ready=0 (backpressure).
//  rr_ptr changes only on a grant; an idle cycle does not rotate priority.
//  Requests are not latched. A requester dropping req_valid before grant loses nothing.
//  Arithmetic:
//    Negative operand (bit w-1 = 1) -> two's complement negate; else pass through.
//    abs(-2^(w-1)) = 16'h8000 (wraps) unless ABS_SAT_EN.
//  Reset mid-operation: a pending result is discarded, no grant on the reset cycle, priority returns to requester 0.
//  Out-of-range grant indices (>= N) never occur.
// CONFIGURATION
//  ABS_SAT_EN defined:
//    Operand 16'h8000 yields res_data=16'h7FFF and res_ovf=1 for that result.
//    res_ovf is cleared with each new result.
//  ABS_SAT_EN undefined:
//    Operand 16'h8000 yields 16'h8000.
//    res_ovf is tied 0.
// TESTING
//  1. Reset: assert rst 2 cycles with all req_valid=1 -> req_ready=0, res_valid=0, res_data=0 throughout.
//  2. Single request: req_valid=4'b0100, data2=16'hFFF6 (-10), res_ready=1 -> next cycle res_data=16'h000A, res_id=2, res_valid=1.
//  3. Fairness: all 4 valid continuously, res_ready=1 -> grant order 0,1,2,3,0,1; 1 result/cycle; values match abs of each.
//  4. Backpressure: res_ready=0 for 3 cycles with req_valid=4'b0011 -> req_ready=0 and res_data/res_id stable. Then res_ready=1 -> next grant goes to the requester after the last id.
//  5. Edge values: 16'h0000->0000, 16'h7FFF->7FFF, 16'h8000->8000 with ovf=0 (macro off), or 7FFF with ovf=1 (ABS_SAT_EN).
//  6. Reset mid-HOLD: result pending, rst=1 one cycle -> res_valid=0, rr_ptr=0. With req_valid=4'b1001, req 0 wins after reset.

Source files
------------

// File: rtl/abs_arbiter.sv
// Round-robin arbiter sharing one absolute-value datapath among N requesters.
// Define ABS_SAT_EN to saturate abs(-2^(w-1)) to the max positive value.
module abs_arbiter #(
  parameter int w   = 16,
  parameter int N   = 4,
  parameter int IDW = 2
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N-1:0]   req_valid,
  input  logic [N*w-1:0] req_data,
  output logic [N-1:0]   req_ready,
  output logic           res_valid,
  output logic [w-1:0]   res_data,
  output logic [IDW-1:0] res_id,
  output logic           res_ovf,
  input  logic           res_ready
);

  typedef enum logic {IDLE, HOLD} state_t;

  state_t         state;
  logic [IDW-1:0] rr_ptr;
  logic           accept;
  logic           gnt_any;
  logic [IDW-1:0] gnt_idx;
  logic [w-1:0]   gnt_op;
  logic [w-1:0]   mag;
  logic [w-1:0]   abs_val;
  int             sel;

  assign accept = !rst && (state == IDLE || res_ready);

  // Scan from rr_ptr upward, wrapping at N; first valid wins.
  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = '0;
    gnt_op  = '0;
    sel     = 0;
    for (int k = 0; k < N; k++) begin
      sel = int'(rr_ptr) + k;
      if (sel >= N) sel = sel - N;
      if (!gnt_any && accept && req_valid[sel]) begin
        gnt_any = 1'b1;
        gnt_idx = IDW'(sel);
        gnt_op  = req_data[sel*w +: w];
      end
    end
  end

  assign req_ready = gnt_any ? (N'(1) << gnt_idx) : '0;
  assign mag       = gnt_op[w-1] ? -gnt_op : gnt_op;

`ifdef ABS_SAT_EN
  logic min_neg;
  assign min_neg = gnt_op == {1'b1, {(w-1){1'b0}}};
  assign abs_val = min_neg ? {1'b0, {(w-1){1'b1}}} : mag;
`else
  assign abs_val = mag;
  assign res_ovf = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      res_valid <= 1'b0;
      res_data  <= '0;
      res_id    <= '0;
`ifdef ABS_SAT_EN
      res_ovf   <= 1'b0;
`endif
    end else if (gnt_any) begin
      state     <= HOLD;
      res_valid <= 1'b1;
      res_data  <= abs_val;
      res_id    <= gnt_idx;
      rr_ptr    <= (gnt_idx == IDW'(N-1)) ? '0 : gnt_idx + IDW'(1);
`ifdef ABS_SAT_EN
      res_ovf   <= min_neg;
`endif
    end else if (res_valid && res_ready) begin
      state     <= IDLE;
      res_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_abs_arbiter.sv
// Randomized + directed bench for abs_arbiter against a transaction-level model.
// Honours ABS_SAT_EN the same way as the design.
module tb_abs_arbiter;

  localparam int W   = 16;
  localparam int N   = 4;
  localparam int IDW = 2;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req_valid;
  logic [N*W-1:0] req_data;
  logic [N-1:0]   req_ready;
  logic           res_valid;
  logic [W-1:0]   res_data;
  logic [IDW-1:0] res_id;
  logic           res_ovf;
  logic           res_ready;

  int checks = 0;
  int errors = 0;

  // model: one result slot plus the rotating start index
  bit       m_valid;
  int       m_data;
  int       m_id;
  int       m_ovf;
  int       m_ptr;
  logic [N-1:0] last_gnt;
  logic [W-1:0] o_data;
  logic         o_ovf;
  logic [IDW-1:0] o_id;

  abs_arbiter #(.w(W), .N(N), .IDW(IDW)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready),
    .res_valid(res_valid), .res_data(res_data),
    .res_id(res_id), .res_ovf(res_ovf),
    .res_ready(res_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  function automatic void ref_abs(input logic [W-1:0] x,
                                  output int v, output int o);
    int s;
    s = int'($signed(x));
    v = (s < 0) ? -s : s;
    o = 0;
    if (v == 32768) begin
`ifdef ABS_SAT_EN
      v = 32767;
      o = 1;
`endif
    end
  endfunction

  task automatic step(input logic r, input logic [N-1:0] v,
                      input logic [N*W-1:0] d, input logic rr);
    int g;
    int a;
    int o;
    logic [N-1:0] exp_gnt;
    @(negedge clk);
    chk("res_valid", 32'(res_valid), 32'(m_valid));
    chk("res_data", 32'(res_data), m_data);
    chk("res_id", 32'(res_id), m_id);
    chk("res_ovf", 32'(res_ovf), m_ovf);
    o_data = res_data;
    o_ovf  = res_ovf;
    o_id   = res_id;
    rst = r; req_valid = v; req_data = d; res_ready = rr;
    #1;
    g = -1;
    if (!r && (!m_valid || rr))
      for (int k = 0; k < N; k++)
        if (g < 0 && v[(m_ptr + k) % N]) g = (m_ptr + k) % N;
    exp_gnt = (g < 0) ? '0 : N'(1 << g);
    chk("req_ready", 32'(req_ready), 32'(exp_gnt));
    last_gnt = req_ready;
    if (r) begin
      m_valid = 0; m_data = 0; m_id = 0; m_ovf = 0; m_ptr = 0;
    end else if (g >= 0) begin
      ref_abs(d[g*W +: W], a, o);
      m_valid = 1; m_data = a; m_id = g; m_ovf = o;
      m_ptr = (g + 1) % N;
    end else if (m_valid && rr) begin
      m_valid = 0;
    end
  endtask

  function automatic logic [W-1:0] rnd_op();
    case ($urandom_range(0, 5))
      0: return 16'h8000;
      1: return 16'h7FFF;
      2: return 16'h0000;
      3: return 16'hFFFF;
      default: return W'($urandom);
    endcase
  endfunction

  logic [N*W-1:0] d;
  int exp_order[6] = '{0, 1, 2, 3, 0, 1};
  logic [IDW-1:0] held_id;
  logic [W-1:0]   held_data;

  initial begin
    rst = 1'b1; req_valid = '0; req_data = '0; res_ready = 1'b0;
    m_valid = 0; m_data = 0; m_id = 0; m_ovf = 0; m_ptr = 0;
    @(posedge clk);

    d = {16'h0004, 16'hFFFD, 16'h0002, 16'hFFFF};
    step(1, 4'b1111, d, 1);
    step(1, 4'b1111, d, 1);
    chk("rst_ready", 32'(last_gnt), 0);

    d = '0;
    d[2*W +: W] = 16'hFFF6;
    step(0, 4'b0100, d, 1);
    chk("single_gnt", 32'(last_gnt), 32'h4);
    step(0, 4'b0000, d, 1);
    chk("single_data", 32'(o_data), 32'h000A);
    chk("single_id", 32'(o_id), 2);

    step(1, 4'b0000, d, 1);
    d = {16'hFFF0, 16'h0030, 16'h8001, 16'h0011};
    for (int i = 0; i < 6; i++) begin
      step(0, 4'b1111, d, 1);
      chk("fair_gnt", 32'(last_gnt), 32'(1 << exp_order[i]));
    end

    step(0, 4'b0011, d, 0);
    held_id = o_id; held_data = o_data;
    for (int i = 0; i < 3; i++) begin
      step(0, 4'b0011, d, 0);
      chk("bp_ready", 32'(last_gnt), 0);
      chk("bp_id", 32'(o_id), 32'(held_id));
      chk("bp_data", 32'(o_data), 32'(held_data));
    end
    step(0, 4'b0011, d, 1);
    chk("bp_next", 32'(last_gnt), 32'h1);

    foreach (exp_order[i]) begin end
    d = '0;
    d[0 +: W] = 16'h0000;
    step(0, 4'b0001, d, 1);
    step(0, 4'b0000, d, 1);
    chk("edge_0000", 32'(o_data), 32'h0000);
    d[0 +: W] = 16'h7FFF;
    step(0, 4'b0001, d, 1);
    step(0, 4'b0000, d, 1);
    chk("edge_7fff", 32'(o_data), 32'h7FFF);
    d[0 +: W] = 16'h8000;
    step(0, 4'b0001, d, 1);
    step(0, 4'b0000, d, 1);
`ifdef ABS_SAT_EN
    chk("edge_8000", 32'(o_data), 32'h7FFF);
    chk("edge_ovf", 32'(o_ovf), 1);
`else
    chk("edge_8000", 32'(o_data), 32'h8000);
    chk("edge_ovf", 32'(o_ovf), 0);
`endif

    d = {16'h0009, 16'h0000, 16'h0000, 16'hFFFE};
    step(0, 4'b0100, {16'h0, 16'h0005, 32'h0}, 0);
    step(0, 4'b0000, d, 0);
    step(1, 4'b1001, d, 0);
    chk("rst_mid_ready", 32'(last_gnt), 0);
    step(0, 4'b1001, d, 1);
    chk("rst_mid_valid", 32'(o_ovf | 1'b0), 0);
    chk("rst_mid_gnt", 32'(last_gnt), 32'h1);

    for (int i = 0; i < 400; i++) begin
      for (int j = 0; j < N; j++) d[j*W +: W] = rnd_op();
      step($urandom_range(0, 60) == 0, N'($urandom),
           d, $urandom_range(0, 3) != 0);
    end
    step(0, '0, '0, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
